// File: rtl/qc_row_xor_accumulator_if.sv
// Beat input and result output bus of the QC-LDPC row XOR accumulator.
// The slave modport is the accumulator's view; master is the shifter/consumer side.
interface qc_row_xor_accumulator_if #(
    parameter int unsigned MAXZ     = 81,
    parameter int unsigned MAX_COLS = 24,
    parameter int unsigned MAX_ROWS = 12
);
    localparam int unsigned ROW_W  = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
    localparam int unsigned BEAT_W = $clog2(MAX_COLS + 1);

    logic              flush;
    logic              valid_in;
    logic [MAXZ-1:0]   in_data;
    logic              last_in;
    logic              out_valid;
    logic              out_ready;
    logic [MAXZ-1:0]   out_data;
    logic [ROW_W-1:0]  out_row;
    logic [BEAT_W-1:0] out_beats;
    logic              overflow;
    logic              col_err;

    modport slave (
        input  flush, valid_in, in_data, last_in, out_ready,
        output out_valid, out_data, out_row, out_beats, overflow, col_err
    );

    modport master (
        output flush, valid_in, in_data, last_in, out_ready,
        input  out_valid, out_data, out_row, out_beats, overflow, col_err
    );
endinterface

// File: rtl/qc_row_xor_accumulator.sv
// XOR-accumulates the rotated circulant words of one base-matrix row and queues one
// check word per row in a small shift-register FIFO; the input side never stalls.
module qc_row_xor_accumulator #(
    parameter int unsigned MAXZ      = 81,
    parameter int unsigned MAX_COLS  = 24,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned MAX_ROWS  = 12
) (
    input  logic                     CLK,
    input  logic                     rst,
    qc_row_xor_accumulator_if.slave  bus
);
    localparam int unsigned ROW_W  = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;
    localparam int unsigned BEAT_W = $clog2(MAX_COLS + 1);
    localparam int unsigned CNT_W  = $clog2(OUT_DEPTH + 1);

    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_COLS);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(MAX_ROWS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(OUT_DEPTH);

    typedef struct packed {
        logic [MAXZ-1:0]   data;
        logic [ROW_W-1:0]  row;
        logic [BEAT_W-1:0] beats;
    } entry_t;

    typedef enum logic {S_IDLE, S_ROW} state_t;

    state_t            state_q, state_d;
    logic [MAXZ-1:0]   acc_q, acc_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    entry_t            fifo_q [OUT_DEPTH];
    entry_t            fifo_d [OUT_DEPTH];
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic              col_err_q, col_err_d;

    logic              beat, push, pop, full, push_ok;
    logic [BEAT_W-1:0] beat_inc;
    logic [MAXZ-1:0]   acc_x;
    logic [CNT_W-1:0]  wr_idx;
    entry_t            new_entry;

    // Row FSM, accumulator and FIFO next-state
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beat_d      = beat_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        fifo_d      = fifo_q;
        overflow_d  = overflow_q;
        col_err_d   = col_err_q;
        out_valid_d = out_valid_q;
        push        = 1'b0;
        new_entry   = '0;

        beat     = bus.valid_in & ~bus.flush;
        beat_inc = (beat_q == BEAT_MAX) ? BEAT_MAX : beat_q + BEAT_W'(1);
        acc_x    = (state_q == S_ROW) ? (acc_q ^ bus.in_data) : bus.in_data;

        if (beat) begin
            if (beat_q == BEAT_MAX) col_err_d = 1'b1;
            if (bus.last_in) begin
                push      = 1'b1;
                new_entry = '{data: acc_x, row: row_q, beats: beat_inc};
                state_d   = S_IDLE;
                acc_d     = '0;
                beat_d    = '0;
                row_d     = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                state_d = S_ROW;
                acc_d   = acc_x;
                beat_d  = beat_inc;
            end
        end

        pop     = out_valid_q & bus.out_ready & ~bus.flush;
        full    = (cnt_q == CNT_FULL);
        push_ok = push & (~full | pop);
        if (push & full & ~pop) overflow_d = 1'b1;

        // Head lives in slot 0 so it feeds the outputs straight from a flop
        wr_idx = cnt_q - CNT_W'(pop);
        if (pop) begin
            for (int i = 0; i < int'(OUT_DEPTH) - 1; i++) fifo_d[i] = fifo_q[i+1];
            fifo_d[OUT_DEPTH-1] = '0;
        end
        if (push_ok) begin
            for (int i = 0; i < int'(OUT_DEPTH); i++)
                if (CNT_W'(i) == wr_idx) fifo_d[i] = new_entry;
        end
        cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);

        if (bus.flush) begin
            state_d    = S_IDLE;
            acc_d      = '0;
            beat_d     = '0;
            row_d      = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
            col_err_d  = 1'b0;
            for (int i = 0; i < int'(OUT_DEPTH); i++) fifo_d[i] = '0;
        end

        out_valid_d = (cnt_d != '0);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            beat_q      <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            col_err_q   <= 1'b0;
            for (int i = 0; i < int'(OUT_DEPTH); i++) fifo_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beat_q      <= beat_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            col_err_q   <= col_err_d;
            for (int i = 0; i < int'(OUT_DEPTH); i++) fifo_q[i] <= fifo_d[i];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = fifo_q[0].data;
    assign bus.out_row   = fifo_q[0].row;
    assign bus.out_beats = fifo_q[0].beats;
    assign bus.overflow  = overflow_q;
    assign bus.col_err   = col_err_q;
endmodule

// File: tb/tb_qc_row_xor_accumulator.sv
// Scoreboard bench for qc_row_xor_accumulator: a queue holds the expected FIFO contents,
// every cycle the head and sticky flags are compared and handshakes pop the queue.
module tb_qc_row_xor_accumulator;
    localparam int MAXZ = 81, MAX_COLS = 24, DEPTH = 4, MAX_ROWS = 12;

    typedef struct packed {
        logic [MAXZ-1:0] data;
        logic [3:0]      row;
        logic [4:0]      beats;
    } exp_t;

    logic CLK, rst;
    qc_row_xor_accumulator_if #(.MAXZ(MAXZ), .MAX_COLS(MAX_COLS), .MAX_ROWS(MAX_ROWS)) bus ();

    qc_row_xor_accumulator #(.MAXZ(MAXZ), .MAX_COLS(MAX_COLS), .OUT_DEPTH(DEPTH),
                             .MAX_ROWS(MAX_ROWS)) dut (.CLK(CLK), .rst(rst), .bus(bus));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    exp_t            sb[$];
    logic [MAXZ-1:0] m_acc;
    bit              m_active, m_ovf, m_cerr;
    int              m_beats, m_row;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_acc = '0; m_active = 0; m_beats = 0; m_row = 0; m_ovf = 0; m_cerr = 0;
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance the model at the edge
    task automatic step(input logic v, input logic l, input logic [MAXZ-1:0] d,
                        input logic rdy, input logic fl);
        exp_t h, e;
        bit pop, push;
        int nb;
        logic [MAXZ-1:0] res;
        bus.valid_in = v; bus.last_in = l; bus.in_data = d;
        bus.out_ready = rdy; bus.flush = fl;
        @(negedge CLK);
        check_eq("out_valid", 128'(bus.out_valid), 128'(sb.size() != 0));
        h = (sb.size() != 0) ? sb[0] : '0;
        check_eq("out_data", 128'(bus.out_data), 128'(h.data));
        check_eq("out_row", 128'(bus.out_row), 128'(h.row));
        check_eq("out_beats", 128'(bus.out_beats), 128'(h.beats));
        check_eq("overflow", 128'(bus.overflow), 128'(m_ovf));
        check_eq("col_err", 128'(bus.col_err), 128'(m_cerr));
        if (fl) begin
            model_clear();
        end else begin
            pop  = (sb.size() != 0) && rdy;
            push = 0;
            e    = '0;
            if (v) begin
                if (m_beats == MAX_COLS) m_cerr = 1;
                nb  = (m_beats == MAX_COLS) ? MAX_COLS : m_beats + 1;
                res = m_active ? (m_acc ^ d) : d;
                if (l) begin
                    e = '{data: res, row: 4'(m_row), beats: 5'(nb)};
                    if (sb.size() < DEPTH || pop) push = 1;
                    else m_ovf = 1;
                    m_row = (m_row + 1) % MAX_ROWS;
                    m_acc = '0; m_active = 0; m_beats = 0;
                end else begin
                    m_acc = res; m_active = 1; m_beats = nb;
                end
            end
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rdy, 1'b0);
    endtask

    initial begin
        logic [MAXZ-1:0] rd;
        rst = 1'b1;
        bus.valid_in = 0; bus.last_in = 0; bus.in_data = '0; bus.out_ready = 0; bus.flush = 0;
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_valid", 128'(bus.out_valid), 128'(0));
        check_eq("rst_data", 128'(bus.out_data), 128'(0));
        rst = 1'b0;

        // T1: single-beat row
        step(1, 1, 81'h1, 1, 0);
        check_eq("t1_valid", 128'(bus.out_valid), 128'(1));
        check_eq("t1_data", 128'(bus.out_data), 128'(1));
        check_eq("t1_row", 128'(bus.out_row), 128'(0));
        check_eq("t1_beats", 128'(bus.out_beats), 128'(1));
        idle(2, 1);

        // T2: three-beat row XORs to zero
        step(1, 0, 81'h3, 1, 0);
        step(1, 0, 81'h5, 1, 0);
        check_eq("t2_nopart", 128'(bus.out_valid), 128'(0));
        step(1, 1, 81'h6, 1, 0);
        check_eq("t2_data", 128'(bus.out_data), 128'(0));
        check_eq("t2_beats", 128'(bus.out_beats), 128'(3));
        check_eq("t2_row", 128'(bus.out_row), 128'(1));
        idle(2, 1);

        // T3: overflow with consumer stalled, then push+pop on full
        step(1, 0, 81'h0, 0, 1);
        for (int k = 1; k <= 5; k++) step(1, 1, MAXZ'(k), 0, 0);
        check_eq("t3_ovf", 128'(bus.overflow), 128'(1));
        idle(2, 0);
        step(1, 1, 81'h9, 1, 0);
        idle(6, 1);

        // T4: full FIFO, pop and push together without overflow
        step(0, 0, '0, 0, 1);
        for (int k = 1; k <= 4; k++) step(1, 1, MAXZ'(k + 16), 0, 0);
        step(1, 1, 81'h1f, 1, 0);
        check_eq("t4_ovf", 128'(bus.overflow), 128'(0));
        check_eq("t4_head", 128'(bus.out_data), 128'(81'h12));
        idle(6, 1);

        // T5: column overrun
        for (int k = 0; k < 25; k++) step(1, 0, 81'h1, 1, 0);
        check_eq("t5_cerr", 128'(bus.col_err), 128'(1));
        step(1, 1, 81'h1, 1, 0);
        check_eq("t5_beats", 128'(bus.out_beats), 128'(24));
        check_eq("t5_data", 128'(bus.out_data), 128'(0));
        idle(2, 1);

        // T6: async reset mid-row with two queued entries
        step(1, 1, 81'ha, 0, 0);
        step(1, 1, 81'hb, 0, 0);
        step(1, 0, 81'hc, 0, 0);
        #2 rst = 1'b1;
        bus.valid_in = 0; bus.last_in = 0;
        #1;
        check_eq("t6_valid", 128'(bus.out_valid), 128'(0));
        check_eq("t6_data", 128'(bus.out_data), 128'(0));
        check_eq("t6_row", 128'(bus.out_row), 128'(0));
        check_eq("t6_beats", 128'(bus.out_beats), 128'(0));
        model_clear();
        @(posedge CLK);
        #1 rst = 1'b0;
        step(1, 1, 81'h7, 1, 0);
        check_eq("t6_data7", 128'(bus.out_data), 128'(7));
        check_eq("t6_row0", 128'(bus.out_row), 128'(0));
        idle(2, 1);
        step(1, 1, 81'hd, 1, 1);
        check_eq("t6_flush", 128'(bus.out_valid), 128'(0));
        idle(2, 1);

        // Random traffic with occasional flush
        for (int k = 0; k < 400; k++) begin
            rd = MAXZ'({$urandom(), $urandom(), $urandom()});
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), rd,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 60) == 0));
        end
        idle(8, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
